period_meter: RTL and testbench
===============================

# period_meter

Measures the interval, in `clk` cycles, between successive single-cycle `tick` strobes and reports each interval through a valid/ack output register. A timeout fires when no strobe arrives within a programmed limit. It is the receive-side counterpart of the periodic done-pulse generators in the LED matrix controller. It checks scan-row and PWM frame strobes on hardware and in simulation, and its results drive the status/debug readout.

## Interface
Parameters:
- `MAX_NS`, default 1_000_000: longest legal interval, in ns.
- `CLKPD_NS`, default 10: clock period in ns (100 MHz).
- `MAX_COUNT`, default `MAX_NS/CLKPD_NS`: timeout limit, in cycles. Must be ≥ 2.
- `CNT_BITS`, default `$clog2(MAX_COUNT+1)`: width of the counter and of the period registers.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `tick`, in, 1: strobe. Must be synchronous to `clk`, one cycle wide.
- `ack`, in, 1: consumer has taken `period`.
- `period`, out, `CNT_BITS`: last measured interval, in cycles.
- `valid`, out, 1: `period` holds an unconsumed measurement.
- `overrun`, out, 1: sticky flag; a measurement was overwritten before it was acked.
- `timeout`, out, 1: one-cycle pulse when no `tick` arrives within `MAX_COUNT` cycles.
- `busy`, out, 1: high while in MEASURE.
- `min_period`, out, `CNT_BITS`: smallest period seen. Present only with `PERIOD_METER_STATS_EN`.
- `max_period`, out, `CNT_BITS`: largest period seen. Present only with `PERIOD_METER_STATS_EN`.

## Operation
- FSM has two states, IDLE and MEASURE. Reset state is IDLE.
- **IDLE**:
  - `tick` → MEASURE, `cnt` ← 1.
  - No `tick` → `cnt` holds at 0.
- **MEASURE**, evaluated in priority order:
  - `tick`: `period` ← `cnt`, `valid` ← 1, `cnt` ← 1, stay in MEASURE.
  - else if `cnt == MAX_COUNT`: `timeout` ← 1 for one cycle, `cnt` ← 0, go to IDLE. `period` and `valid` are unchanged.
  - else `cnt` ← `cnt + 1`.
- **Measured value**: ticks sampled at cycles t0 and t1 give `period = t1 − t0`. A generator pulsing every N cycles measures exactly N.
- **Tick on the boundary**: a `tick` arriving when `cnt == MAX_COUNT` is a valid measurement of `MAX_COUNT`. No timeout fires.
- **Handshake**:
  - `valid` rises when a period is captured.
  - `valid` falls on the cycle after `ack && valid`, unless a new capture occurs in that same cycle; then `valid` stays 1 and `period` takes the new value.
  - `ack` while `valid == 0` is ignored.
- **Overrun**:
  - A capture while `valid && !ack` overwrites `period` with the newest value and sets `overrun`.
  - `overrun` clears on the cycle after an `ack` that is accepted while `valid == 1`.
  - If a new overrun happens in that same cycle, the set wins.
- **Reset mid-measurement**: abandons the count and returns to IDLE. No `timeout` pulse and no capture occur.
- **Reset values**:
  - `period` = 0, `valid` = 0, `overrun` = 0, `timeout` = 0, `busy` = 0, `cnt` = 0.
  - `min_period` = all ones, `max_period` = 0.
- **Arithmetic**: `cnt` never exceeds `MAX_COUNT`; there is no wrap. All comparisons are unsigned at `CNT_BITS` width.

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- `period`, `valid`, `overrun` and `busy` change on the edge that samples the triggering `tick`/`ack`, and are visible in the following cycle.
- `timeout` is high for exactly one cycle: the cycle after the edge where `cnt == MAX_COUNT` is sampled without a `tick`.
- The first `tick` after reset or after a timeout only arms the block; the capture comes on the second `tick`.
- Minimum measurable period is 1, from ticks on consecutive cycles.

## Configuration
- Macro: `PERIOD_METER_STATS_EN`.
- **Defined**:
  - `min_period`/`max_period` exist.
  - On every capture, `min_period` ← min(`min_period`, new) and `max_period` ← max(`max_period`, new), both updated in the same cycle as `period`.
  - Timeouts do not update either register.
  - Only `rst` clears them.
- **Undefined**: both ports and both registers are absent. All other behaviour is identical.

## Structure
- Package `period_meter_pkg`:
  - state enum typedef `pm_state_t` {`PM_IDLE`, `PM_MEASURE`};
  - default constant `PM_CLKPD_NS` = 10.
- Sub-module `interval_counter`: a saturating up-counter with `clr`/`load1`/`en`, output `cnt`, and an `at_max` flag.
- The top level holds the FSM, the capture/handshake registers, and the optional stats.

## Test plan
All scenarios use `MAX_NS`=1000 and `CLKPD_NS`=10, so `MAX_COUNT`=100 and `CNT_BITS`=7.
- Ticks every 25 cycles, with `ack` 2 cycles after each `valid` → `period`=25 every time, `overrun`=0, `timeout` never fires.
- Ticks at cycles 10 and 11 → `period`=1. Ticks at 0 and 100 → `period`=100 with no `timeout`. Ticks at 0 and 101 → `timeout` pulses at the 100-cycle boundary; the tick at 101 re-arms the block and nothing is captured.
- Ticks every 10 cycles with `ack` held low → `period`=10, `overrun` rises on the second capture; a single `ack` clears `valid` and `overrun` one cycle later.
- `ack` in the same cycle as a capture → `valid` stays 1, `period` shows the new value, `overrun` stays 0.
- Assert `rst` 40 cycles into a measurement → all outputs take their reset values, no `timeout` pulse; the next two ticks 30 cycles apart give `period`=30.
- With `PERIOD_METER_STATS_EN`: periods 30, 12, 57 → `min_period`=12, `max_period`=57; a timeout afterwards leaves both unchanged.

Source files
------------

// File: rtl/period_meter_pkg.sv
// period_meter_pkg: shared types and defaults for the period meter.
//   pm_state_t  - measurement FSM state (PM_IDLE, PM_MEASURE)
//   PM_CLKPD_NS - default clock period in ns (100 MHz)
package period_meter_pkg;

   typedef enum logic [0:0] {
      PM_IDLE    = 1'b0,
      PM_MEASURE = 1'b1
   } pm_state_t;

   localparam int unsigned PM_CLKPD_NS = 10;

endpackage

// File: rtl/period_meter_if.sv
// period_meter_if: strobe input and measurement result bundle.
//   tick       - strobe, one clk cycle wide, synchronous to clk
//   ack        - consumer has taken period
//   period     - last measured interval in cycles
//   valid      - period holds an unconsumed measurement
//   overrun    - sticky: a measurement was overwritten before ack
//   timeout    - one-cycle pulse when no tick arrives in time
//   busy       - a measurement is in progress
//   min_period - smallest period seen (PERIOD_METER_STATS_EN only)
//   max_period - largest period seen  (PERIOD_METER_STATS_EN only)
// Modports: master = strobe source / consumer, slave = the meter.
// Optional feature macro: PERIOD_METER_STATS_EN.
interface period_meter_if #(
   parameter int unsigned CNT_BITS = 7
);
   logic                tick;
   logic                ack;
   logic [CNT_BITS-1:0] period;
   logic                valid;
   logic                overrun;
   logic                timeout;
   logic                busy;
`ifdef PERIOD_METER_STATS_EN
   logic [CNT_BITS-1:0] min_period;
   logic [CNT_BITS-1:0] max_period;

   modport master (
      output tick, ack,
      input  period, valid, overrun, timeout, busy, min_period, max_period
   );
   modport slave (
      input  tick, ack,
      output period, valid, overrun, timeout, busy, min_period, max_period
   );
`else
   modport master (
      output tick, ack,
      input  period, valid, overrun, timeout, busy
   );
   modport slave (
      input  tick, ack,
      output period, valid, overrun, timeout, busy
   );
`endif
endinterface

// File: rtl/period_meter_interval_counter.sv
// interval_counter: saturating up-counter for the period meter.
//   clk, rst - clock, synchronous active-high reset
//   clr      - force count to 0
//   load1    - force count to 1 (a tick starts a new interval)
//   en       - count up, saturating at MAX_COUNT
//   cnt      - current count
//   at_max   - cnt equals MAX_COUNT
// Priority: rst/clr, then load1, then en.
module interval_counter #(
   parameter int unsigned MAX_COUNT = 100,
   parameter int unsigned CNT_BITS  = 7
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic                load1,
   input  logic                en,
   output logic [CNT_BITS-1:0] cnt,
   output logic                at_max
);
   localparam logic [CNT_BITS-1:0] MAX_VAL = CNT_BITS'(MAX_COUNT);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (load1) begin
         cnt <= CNT_BITS'(1);
      end else if (en && !at_max) begin
         cnt <= cnt + CNT_BITS'(1);
      end
   end

   assign at_max = (cnt == MAX_VAL);
endmodule

// File: rtl/period_meter.sv
// period_meter: measures clk cycles between successive tick strobes and
// reports each interval through a valid/ack register; pulses timeout when
// no tick arrives within MAX_COUNT cycles.
//   clk, rst - clock, synchronous active-high reset
//   bus      - period_meter_if slave (tick/ack in; period, valid,
//              overrun, timeout, busy and optional min/max out)
// Optional feature macro: PERIOD_METER_STATS_EN (min/max period tracking).
module period_meter
   import period_meter_pkg::*;
#(
   parameter int unsigned MAX_NS    = 1_000_000,
   parameter int unsigned CLKPD_NS  = PM_CLKPD_NS,
   parameter int unsigned MAX_COUNT = MAX_NS / CLKPD_NS,
   parameter int unsigned CNT_BITS  = $clog2(MAX_COUNT + 1)
) (
   input logic           clk,
   input logic           rst,
   period_meter_if.slave bus
);
   pm_state_t           state;
   logic [CNT_BITS-1:0] cnt;
   logic                at_max;
   logic                measuring;
   logic                capture;
   logic                accept;
   logic [CNT_BITS-1:0] period_q;
   logic                valid_q;
   logic                overrun_q;
   logic                timeout_q;
   logic                busy_q;

   assign measuring = (state == PM_MEASURE);
   assign capture   = measuring && bus.tick;
   assign accept    = bus.ack && valid_q;

   // A tick always restarts the interval at 1; a tick on the boundary
   // wins over the timeout clear.
   interval_counter #(
      .MAX_COUNT (MAX_COUNT),
      .CNT_BITS  (CNT_BITS)
   ) u_counter (
      .clk    (clk),
      .rst    (rst),
      .clr    (measuring && !bus.tick && at_max),
      .load1  (bus.tick),
      .en     (measuring && !bus.tick),
      .cnt    (cnt),
      .at_max (at_max)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= PM_IDLE;
         period_q  <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
         timeout_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         timeout_q <= 1'b0;
         case (state)
            PM_IDLE: begin
               if (bus.tick) begin
                  state  <= PM_MEASURE;
                  busy_q <= 1'b1;
               end
            end
            PM_MEASURE: begin
               if (!bus.tick && at_max) begin
                  state     <= PM_IDLE;
                  busy_q    <= 1'b0;
                  timeout_q <= 1'b1;
               end
            end
            default: begin
               state  <= PM_IDLE;
               busy_q <= 1'b0;
            end
         endcase

         // A capture in the same cycle as an accepted ack keeps valid set
         // and still clears overrun; an unacked overwrite sets it.
         if (capture) begin
            period_q <= cnt;
            valid_q  <= 1'b1;
            if (valid_q && !bus.ack) begin
               overrun_q <= 1'b1;
            end else if (accept) begin
               overrun_q <= 1'b0;
            end
         end else if (accept) begin
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
         end
      end
   end

   assign bus.period  = period_q;
   assign bus.valid   = valid_q;
   assign bus.overrun = overrun_q;
   assign bus.timeout = timeout_q;
   assign bus.busy    = busy_q;

`ifdef PERIOD_METER_STATS_EN
   logic [CNT_BITS-1:0] min_q;
   logic [CNT_BITS-1:0] max_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         min_q <= '1;
         max_q <= '0;
      end else if (capture) begin
         if (cnt < min_q) min_q <= cnt;
         if (cnt > max_q) max_q <= cnt;
      end
   end

   assign bus.min_period = min_q;
   assign bus.max_period = max_q;
`endif
endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: directed testbench for period_meter with
// MAX_NS=1000, CLKPD_NS=10 (MAX_COUNT=100, CNT_BITS=7).
// A tick-timestamp model predicts every output each cycle; literal
// checks pin key results of each scenario.
module tb_period_meter;
   localparam int MAXC = 100;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tick = 1'b0;
   logic ack = 1'b0;

   period_meter_if #(.CNT_BITS(7)) bus ();

   assign bus.tick = tick;
   assign bus.ack  = ack;

   period_meter #(
      .MAX_NS   (1000),
      .CLKPD_NS (10)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int to_seen  = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Model: remembers the cycle of the last accepted tick and derives
   // intervals as timestamp differences.
   int cyc = 0;
   int t_last = 0;
   bit armed = 0;
   bit started = 0;
   int e_period, e_valid, e_ovr, e_to, e_busy, e_min, e_max;
   int m_d;
   bit m_cap, m_acc;

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         armed = 0; e_period = 0; e_valid = 0; e_ovr = 0;
         e_to = 0; e_busy = 0; e_min = 127; e_max = 0;
      end else begin
         e_to  = 0;
         m_cap = 0;
         m_acc = ack && (e_valid != 0);
         if (armed && tick) begin
            m_cap = 1; m_d = cyc - t_last; t_last = cyc;
         end else if (armed && (cyc - t_last == MAXC)) begin
            e_to = 1; armed = 0;
         end else if (!armed && tick) begin
            armed = 1; t_last = cyc;
         end
         if (m_cap) begin
            if (e_valid != 0 && !ack) e_ovr = 1;
            else if (m_acc) e_ovr = 0;
            e_valid  = 1;
            e_period = m_d;
            if (m_d < e_min) e_min = m_d;
            if (m_d > e_max) e_max = m_d;
         end else if (m_acc) begin
            e_valid = 0; e_ovr = 0;
         end
         e_busy = armed;
      end
      started = 1;
   end

   always @(negedge clk) begin
      if (started) begin
         chk("period",  int'(bus.period),  e_period);
         chk("valid",   int'(bus.valid),   e_valid);
         chk("overrun", int'(bus.overrun), e_ovr);
         chk("timeout", int'(bus.timeout), e_to);
         chk("busy",    int'(bus.busy),    e_busy);
`ifdef PERIOD_METER_STATS_EN
         chk("min_period", int'(bus.min_period), e_min);
         chk("max_period", int'(bus.max_period), e_max);
`endif
         if (bus.timeout) to_seen++;
      end
   end

   // Drive inputs for the next rising edge.
   task automatic step(input bit t, input bit a);
      @(negedge clk);
      tick = t;
      ack  = a;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0);
   endtask

   // Settle: let the last driven values be sampled, observe results.
   task automatic settle();
      step(0, 0);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1; tick = 0; ack = 0;
      @(negedge clk);
      rst = 0;
   endtask

   task automatic pin(input string name, input int act, input int mdl, input int lit);
      chk({name, "_dut"}, act, lit);
      chk({name, "_model"}, mdl, lit);
   endtask

   int to0;

   initial begin
      // Reset state
      @(negedge clk);
      @(negedge clk);
      rst = 0;
      pin("rst_period", int'(bus.period), e_period, 0);
      pin("rst_valid", int'(bus.valid), e_valid, 0);
      pin("rst_busy", int'(bus.busy), e_busy, 0);

      // Ticks every 25 cycles, ack two cycles after valid
      to0 = to_seen;
      step(1, 0); idle(24);
      for (int k = 0; k < 4; k++) begin
         step(1, 0); step(0, 0); step(0, 1); idle(22);
      end
      settle();
      pin("p25_period", int'(bus.period), e_period, 25);
      pin("p25_overrun", int'(bus.overrun), e_ovr, 0);
      pin("p25_valid", int'(bus.valid), e_valid, 0);
      chk("p25_no_timeout", to_seen - to0, 0);
      do_reset();

      // Minimum period
      step(1, 0); step(1, 0); settle();
      pin("p1_period", int'(bus.period), e_period, 1);
      pin("p1_valid", int'(bus.valid), e_valid, 1);
      do_reset();

      // Tick exactly on the boundary
      to0 = to_seen;
      step(1, 0); idle(99); step(1, 0); settle();
      pin("p100_period", int'(bus.period), e_period, 100);
      chk("p100_no_timeout", to_seen - to0, 0);
      do_reset();

      // One cycle past the boundary: timeout, then re-arm only
      to0 = to_seen;
      step(1, 0); idle(100); step(1, 0); settle();
      chk("p101_timeouts", to_seen - to0, 1);
      pin("p101_valid", int'(bus.valid), e_valid, 0);
      pin("p101_busy", int'(bus.busy), e_busy, 1);
      do_reset();

      // Overrun with ack held low, cleared by one ack
      step(1, 0); idle(9); step(1, 0); idle(9); step(1, 0); idle(3);
      @(negedge clk);
      pin("ovr_set", int'(bus.overrun), e_ovr, 1);
      pin("ovr_period", int'(bus.period), e_period, 10);
      step(0, 1); settle();
      pin("ovr_clr", int'(bus.overrun), e_ovr, 0);
      pin("ovr_valid", int'(bus.valid), e_valid, 0);
      do_reset();

      // Ack in the same cycle as a capture
      step(1, 0); idle(9); step(1, 0); idle(6); step(1, 1); settle();
      pin("ackcap_period", int'(bus.period), e_period, 7);
      pin("ackcap_valid", int'(bus.valid), e_valid, 1);
      pin("ackcap_overrun", int'(bus.overrun), e_ovr, 0);

      // Reset 40 cycles into the measurement started above
      to0 = to_seen;
      idle(37);
      do_reset();
      pin("midrst_period", int'(bus.period), e_period, 0);
      pin("midrst_valid", int'(bus.valid), e_valid, 0);
      pin("midrst_busy", int'(bus.busy), e_busy, 0);
      idle(70);
      chk("midrst_no_timeout", to_seen - to0, 0);
      step(1, 0); idle(29); step(1, 0); settle();
      pin("midrst_p30", int'(bus.period), e_period, 30);
      do_reset();

`ifdef PERIOD_METER_STATS_EN
      pin("stats_rst_min", int'(bus.min_period), e_min, 127);
      pin("stats_rst_max", int'(bus.max_period), e_max, 0);
      to0 = to_seen;
      step(1, 0); idle(29); step(1, 0); idle(11); step(1, 0); idle(56);
      step(1, 0); settle();
      pin("stats_min", int'(bus.min_period), e_min, 12);
      pin("stats_max", int'(bus.max_period), e_max, 57);
      idle(101); settle();
      chk("stats_timeouts", to_seen - to0, 1);
      pin("stats_min_after_to", int'(bus.min_period), e_min, 12);
      pin("stats_max_after_to", int'(bus.max_period), e_max, 57);
`endif

      idle(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
